// File: rtl/llc_cmd_queue.sv
// llc_cmd_queue: filtered FWFT request queue between the trace front-end and the LLC, with read/write/drop statistics
module llc_cmd_queue #(
  parameter int CMDSIZE   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CMDSIZE-1:0]         in_command,
  input  logic [ADDR_BITS-1:0]       in_address,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CMDSIZE-1:0]         out_command,
  output logic [ADDR_BITS-1:0]       out_address,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           reads,
  output logic [CNT_W-1:0]           writes,
  output logic [15:0]                drop_count
);
  localparam int AW = $clog2(DEPTH);
  logic [CMDSIZE-1:0]   r_cmd [DEPTH];
  logic [ADDR_BITS-1:0] r_addr [DEPTH];
  logic [AW-1:0]        r_wp, r_rp;
  logic [AW:0]          r_cnt;
  logic [CNT_W-1:0]     r_reads, r_writes;
  logic [15:0]          r_drops;
  logic                 w_legal, w_acc, w_push, w_drop, w_pop, w_hi;
  // accept/dequeue qualification; codes 8 and up carry no address
  always_comb begin
    w_hi    = in_command >= CMDSIZE'(8);
    w_legal = (in_command <= CMDSIZE'(6)) || (in_command == CMDSIZE'(8)) || (in_command == CMDSIZE'(9));
    w_acc   = in_valid & in_ready;
    w_push  = w_acc & w_legal;
    w_drop  = w_acc & ~w_legal;
    w_pop   = out_valid & out_ready;
  end
  assign in_ready    = r_cnt < (AW+1)'(DEPTH);
  assign out_valid   = r_cnt != '0;
  assign out_command = r_cmd[r_rp];
  assign out_address = r_addr[r_rp];
  assign count       = r_cnt;
  assign reads       = r_reads;
  assign writes      = r_writes;
  assign drop_count  = r_drops;
  // storage is never reset; stale contents are hidden by out_valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_cmd[r_wp]  <= in_command;
      r_addr[r_wp] <= w_hi ? '0 : in_address;
    end
  end
  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // statistics: reads/writes follow dequeued commands, cmd 8 clears them; drops count filtered accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reads  <= '0;
      r_writes <= '0;
      r_drops  <= '0;
    end else begin
      if (w_pop) begin
        if (out_command == CMDSIZE'(8)) begin
          r_reads  <= '0;
          r_writes <= '0;
        end else if ((out_command == CMDSIZE'(0) || out_command == CMDSIZE'(2)) && r_reads != '1) begin
          r_reads <= r_reads + CNT_W'(1);
        end else if (out_command == CMDSIZE'(1) && r_writes != '1) begin
          r_writes <= r_writes + CNT_W'(1);
        end
      end
      if (w_drop && r_drops != 16'hFFFF) r_drops <= r_drops + 16'd1;
    end
  end
endmodule
